micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer_pkg.sv | 41 ++++
 rtl/micro_sequencer_if.sv | 33 +++
 rtl/micro_ir_decode.sv | 21 ++
 rtl/micro_sequencer.sv | 134 +++++++++++++
 tb/tb_micro_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared defines for the micro-sequencer: bus map, micro-word layout,
// opcodes and sequencer state encoding.
package micro_sequencer_pkg;

    localparam int BUS_DATA_W = 8;
    localparam int REG_ADDR_W = 5;
    localparam int OP_W       = 3;

    localparam int MWORD_W = OP_W + 2 * REG_ADDR_W + 2 * BUS_DATA_W;

    localparam int TYPE_LSB = 26;
    localparam int SRC_LSB  = 21;
    localparam int DST_LSB  = 16;
    localparam int IMM_LSB  = 8;
    localparam int TGT_LSB  = 0;

    localparam logic [OP_W-1:0] OP_MOVE    = 3'b000;
    localparam logic [OP_W-1:0] OP_ALU     = 3'b001;
    localparam logic [OP_W-1:0] OP_REGFILE = 3'b010;
    localparam logic [OP_W-1:0] OP_CBRANCH = 3'b011;
    localparam logic [OP_W-1:0] OP_JUMP    = 3'b100;
    localparam logic [OP_W-1:0] OP_HALT    = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT,
        S_HALT
    } seq_state_t;

    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [REG_ADDR_W-1:0] src;
        logic [REG_ADDR_W-1:0] dst;
        logic [BUS_DATA_W-1:0] imm;
        logic [BUS_DATA_W-1:0] tgt;
    } micro_ir_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Micro-ROM port, resource handshake and micro-IR bus of the sequencer.
interface micro_sequencer_if #(
    parameter int MPC_WIDTH = 8
);
    import micro_sequencer_pkg::*;

    logic [MPC_WIDTH-1:0]  mrom_addr;
    logic [MWORD_W-1:0]    mrom_data;
    logic                  should_branch;
    logic                  res_ack;
    logic                  res_req;
    logic                  bus_we;
    logic [OP_W-1:0]       minstr_type;
    logic [REG_ADDR_W-1:0] reg_src;
    logic [REG_ADDR_W-1:0] reg_dst;
    logic [BUS_DATA_W-1:0] imm;
    logic [BUS_DATA_W-1:0] mbranch_target;

    modport master (
        output mrom_addr, res_req, bus_we,
        output minstr_type, reg_src, reg_dst,
        output imm, mbranch_target,
        input  mrom_data, should_branch, res_ack
    );

    modport slave (
        input  mrom_addr, res_req, bus_we,
        input  minstr_type, reg_src, reg_dst,
        input  imm, mbranch_target,
        output mrom_data, should_branch, res_ack
    );

endinterface

// File: rtl/micro_ir_decode.sv
// Slices a raw micro-word into micro-IR fields and flags
// opcodes outside the defined set.
module micro_ir_decode
    import micro_sequencer_pkg::*;
(
    input  logic [MWORD_W-1:0] word,
    output micro_ir_t          ir,
    output logic               legal
);

    always_comb begin
        ir.op  = word[TYPE_LSB +: OP_W];
        ir.src = word[SRC_LSB +: REG_ADDR_W];
        ir.dst = word[DST_LSB +: REG_ADDR_W];
        ir.imm = word[IMM_LSB +: BUS_DATA_W];
        ir.tgt = word[TGT_LSB +: BUS_DATA_W];
    end

    assign legal = (ir.op <= OP_HALT);

endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer: fetches micro-words from a 1-cycle-latency ROM
// and steps them through decode/execute with a resource handshake.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int MPC_WIDTH  = 8,
    parameter int MROM_DEPTH = 256
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic [MPC_WIDTH-1:0] start_addr,
    micro_sequencer_if.master    bus,
    output logic [MPC_WIDTH-1:0] m_pc,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    if (MROM_DEPTH > (1 << MPC_WIDTH)) begin : g_depth_chk
        $error("MROM_DEPTH exceeds micro-PC range");
    end

    seq_state_t           state, state_nx;
    logic [MPC_WIDTH-1:0] pc_q, pc_nx, pc_inc;
    logic                 err_q, err_nx;
    micro_ir_t            ir_q, ir_dec;
    logic                 legal_q, legal_dec;
    logic                 ir_ld;
    logic                 we;
    logic                 req;

    micro_ir_decode u_dec (
        .word  (bus.mrom_data),
        .ir    (ir_dec),
        .legal (legal_dec)
    );

    assign pc_inc = pc_q + 1'b1;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state   <= S_IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
            ir_q    <= '0;
            legal_q <= 1'b1;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            err_q <= err_nx;
            if (ir_ld) begin
                ir_q    <= ir_dec;
                legal_q <= legal_dec;
            end
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        err_nx   = err_q;
        ir_ld    = 1'b0;
        we       = 1'b0;
        req      = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pc_nx    = start_addr;
                    err_nx   = 1'b0;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: begin
                ir_ld    = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                unique case (1'b1)
                    !legal_q: begin
                        err_nx   = 1'b1;
                        state_nx = S_HALT;
                    end
                    ir_q.op == OP_MOVE: begin
                        we    = 1'b1;
                        pc_nx = pc_inc;
                    end
                    ir_q.op == OP_ALU,
                    ir_q.op == OP_REGFILE: begin
                        req      = 1'b1;
                        state_nx = S_WAIT;
                    end
                    ir_q.op == OP_CBRANCH: begin
                        pc_nx = bus.should_branch
                              ? MPC_WIDTH'(ir_q.tgt) : pc_inc;
                    end
                    ir_q.op == OP_JUMP: pc_nx = MPC_WIDTH'(ir_q.tgt);
                    ir_q.op == OP_HALT: state_nx = S_HALT;
                    default: state_nx = S_HALT;
                endcase
            end
            S_WAIT: begin
                req = 1'b1;
                if (bus.res_ack) begin
                    we       = 1'b1;
                    pc_nx    = pc_inc;
                    state_nx = S_FETCH;
                end
            end
            S_HALT: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.mrom_addr      = pc_q;
    assign bus.bus_we         = we;
    assign bus.res_req        = req;
    assign bus.minstr_type    = ir_q.op;
    assign bus.reg_src        = ir_q.src;
    assign bus.reg_dst        = ir_q.dst;
    assign bus.imm            = ir_q.imm;
    assign bus.mbranch_target = ir_q.tgt;

    assign m_pc = pc_q;
    assign busy = (state != S_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: ROM model, delayed-ack resource
// model and per-cycle trace capture after each start.
module tb_micro_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] m_pc;
    logic       busy, done, err;

    logic [28:0] rom [0:255];
    logic        auto_ack, manual_ack;
    int          ack_delay;
    int          age;
    int          total, bad;

    micro_sequencer_if #(.MPC_WIDTH(8)) bus ();

    micro_sequencer #(.MPC_WIDTH(8), .MROM_DEPTH(256)) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .bus        (bus),
        .m_pc       (m_pc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.mrom_data <= rom[bus.mrom_addr];

    always @(posedge clk) age <= bus.res_req ? age + 1 : 0;

    assign bus.res_ack = (auto_ack && bus.res_req && age == ack_delay)
                       || manual_ack;

    logic [7:0] t_addr [0:23];
    logic [4:0] t_dst  [0:23];
    logic [7:0] t_imm  [0:23];
    logic       t_done [0:23];
    logic       t_err  [0:23];
    logic       t_busy [0:23];
    int n_we, n_done, n_req, n_weack, first_we, first_done;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [28:0] mw(input logic [2:0] t,
        input logic [4:0] s, input logic [4:0] d,
        input logic [7:0] i, input logic [7:0] g);
        return {t, s, d, i, g};
    endfunction

    task automatic kick(input logic [7:0] a);
        @(posedge clk);
        #1 start = 1'b1;
        start_addr = a;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // index 0 is the FETCH cycle of the first micro-word
    task automatic capture(input int n);
        n_we = 0; n_done = 0; n_req = 0; n_weack = 0;
        first_we = -1; first_done = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t_addr[i] = bus.mrom_addr;
            t_dst[i]  = bus.reg_dst;
            t_imm[i]  = bus.imm;
            t_done[i] = done;
            t_err[i]  = err;
            t_busy[i] = busy;
            if (bus.bus_we) begin
                n_we++;
                if (first_we < 0) first_we = i;
                if (bus.res_ack) n_weack++;
            end
            if (bus.res_req) n_req++;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
        end
    endtask

    task automatic check_cleared(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_mpc"}, m_pc, 0);
        check({pfx, "_addr"}, bus.mrom_addr, 0);
        check({pfx, "_we"}, bus.bus_we, 0);
        check({pfx, "_req"}, bus.res_req, 0);
        check({pfx, "_fields"}, {bus.minstr_type, bus.reg_src,
              bus.reg_dst, bus.imm, bus.mbranch_target}, 0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0;
        auto_ack = 1'b0; manual_ack = 1'b0; ack_delay = 4;
        bus.should_branch = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = mw(3'b101, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_cleared("rst");

        // MOVE then HALT; a stray ack must not add a write
        rom[8'h10] = mw(3'b000, 5'd1, 5'd2, 8'h5A, 8'h00);
        rom[8'h11] = mw(3'b101, 5'd0, 5'd0, 8'h00, 8'h00);
        manual_ack = 1'b1;
        kick(8'h10);
        capture(12);
        manual_ack = 1'b0;
        check("mv_fetch0", t_addr[0], 8'h10);
        check("mv_busy0", t_busy[0], 1);
        check("mv_we_cnt", n_we, 1);
        check("mv_we_at", first_we, 2);
        check("mv_fetch1", t_addr[3], 8'h11);
        check("mv_ir_dst", t_dst[3], 5'd2);
        check("mv_ir_imm", t_imm[4], 8'h5A);
        check("mv_we_done_gap", first_done - first_we - 1, 3);
        check("mv_done_cnt", n_done, 1);
        check("mv_pc_end", m_pc, 8'h11);
        check("mv_busy_end", busy, 0);

        // ALU word, ack 4 cycles after request rises
        rom[8'h20] = mw(3'b001, 5'd3, 5'd4, 8'h11, 8'h22);
        rom[8'h21] = mw(3'b101, 5'd0, 5'd0, 8'h00, 8'h00);
        auto_ack = 1'b1;
        kick(8'h20);
        capture(16);
        auto_ack = 1'b0;
        check("alu_req_cycles", n_req, 5);
        check("alu_we_cnt", n_we, 1);
        check("alu_we_on_ack", n_weack, 1);
        check("alu_next_fetch", t_addr[7], 8'h21);
        check("alu_pc_end", m_pc, 8'h21);

        // conditional branch taken / not taken
        rom[8'h30] = mw(3'b011, 5'd0, 5'd0, 8'h00, 8'h40);
        bus.should_branch = 1'b1;
        kick(8'h30);
        capture(8);
        check("cbr_taken", t_addr[3], 8'h40);
        check("cbr_no_we", n_we, 0);
        bus.should_branch = 1'b0;
        kick(8'h30);
        capture(8);
        check("cbr_fall", t_addr[3], 8'h31);

        // wrap at the top of the micro-PC range
        rom[8'hFF] = mw(3'b100, 5'd0, 5'd0, 8'h00, 8'h00);
        kick(8'hFF);
        capture(8);
        check("jmp_wrap", t_addr[3], 8'h00);
        rom[8'hFF] = mw(3'b000, 5'd7, 5'd8, 8'h01, 8'h99);
        kick(8'hFF);
        capture(8);
        check("mv_wrap", t_addr[3], 8'h00);
        check("mv_wrap_we", n_we, 1);

        // illegal opcode is sticky until the next start
        rom[8'h50] = mw(3'b111, 5'd0, 5'd0, 8'h00, 8'h00);
        kick(8'h50);
        capture(6);
        check("ill_err", t_err[3], 1);
        check("ill_done", t_done[3], 1);
        check("ill_err_sticky", err, 1);
        kick(8'h10);
        capture(8);
        check("ill_err_clr", t_err[0], 0);

        // reset while waiting, ack arrives the cycle after
        kick(8'h20);
        repeat (4) @(negedge clk);
        check("rw_in_wait", bus.res_req, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        manual_ack = 1'b1;
        @(negedge clk);
        check_cleared("rw");
        @(posedge clk);
        #1 manual_ack = 1'b0;
        @(negedge clk);
        check("rw_idle", busy, 0);
        check("rw_pc", m_pc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
